m_axi_ctrl: RTL and testbench

Single-outstanding AXI initiator that issues single-beat writes and reads to the AXI register slave in this design. A simple command/response port on the user side drives the AW/W/B and AR/R channels. Each transaction gets an incrementing ID, and the returned response is checked against it. The block sits between the control logic (counter/sequencer) and the register-slave AXI port.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/m_axi_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_m_axi_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared types and default widths for the AXI initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } m_state_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/m_axi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : m_axi_ctrl
//  Description : Single-outstanding AXI initiator. Turns one user command
//                into a single-beat AXI write or read, checks the returned
//                ID/last, and presents the result on a response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_axi_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_ID_W,
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic                  clk,
  input  logic                  areset,
  // user command / response port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  // write address channel
  output logic [ID_W-1:0]       awid_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  // write data channel
  output logic [ID_W-1:0]       wid_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  // write response channel
  input  logic [ID_W-1:0]       bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  // read address channel
  output logic [ID_W-1:0]       arid_o,
  output logic [ADDR_W-1:0]     araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  // read data channel
  input  logic [ID_W-1:0]       rid_i,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_WR      = 3'(ST_WR);
  localparam logic [2:0] S_WR_RESP = 3'(ST_WR_RESP);
  localparam logic [2:0] S_RD_ADDR = 3'(ST_RD_ADDR);
  localparam logic [2:0] S_RD_DATA = 3'(ST_RD_DATA);
  localparam logic [2:0] S_RSP     = 3'(ST_RSP);

  localparam logic [1:0] RESP_SLVERR = 2'(SLVERR);

  logic [2:0]          state_q,     state_d;
  logic [ID_W-1:0]     txn_id_q,    txn_id_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [DATA_W/8-1:0] wstrb_q,     wstrb_d;
  // aw_pend/w_pend are the pending flags of WR and drive the valids directly
  logic                aw_pend_q,   aw_pend_d;
  logic                w_pend_q,    w_pend_d;
  logic                arvalid_q,   arvalid_d;
  logic                bready_q,    bready_d;
  logic                rready_q,    rready_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q,  rsp_resp_d;

  logic aw_done;
  logic w_done;

  // Next-state and next-output computation for the whole transaction FSM
  always_comb begin
    state_d     = state_q;
    txn_id_d    = txn_id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    // a channel is done once its valid has already dropped or handshakes now
    aw_done = !aw_pend_q || awready_i;
    w_done  = !w_pend_q  || wready_i;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_WR: begin
        if (aw_pend_q && awready_i) aw_pend_d = 1'b0;
        if (w_pend_q && wready_i)   w_pend_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (bvalid_i) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = (bid_i != txn_id_q) ? RESP_SLVERR : bresp_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (rvalid_i) begin
          rready_d    = 1'b0;
          rsp_rdata_d = rdata_i;
          rsp_resp_d  = ((rid_i != txn_id_q) || !rlast_i) ? RESP_SLVERR : rresp_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_id_d    = txn_id_q + ID_W'(1);
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        aw_pend_d   = 1'b0;
        w_pend_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      txn_id_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      txn_id_q    <= txn_id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign awid_o    = txn_id_q;
  assign awaddr_o  = addr_q;
  assign awvalid_o = aw_pend_q;

  assign wid_o     = txn_id_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = w_pend_q;
  assign wvalid_o  = w_pend_q;

  assign bready_o  = bready_q;

  assign arid_o    = txn_id_q;
  assign araddr_o  = addr_q;
  assign arvalid_o = arvalid_q;

  assign rready_o  = rready_q;

endmodule : m_axi_ctrl
`default_nettype wire

// File: tb/tb_m_axi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_axi_ctrl
//  Description : Directed self-checking bench for m_axi_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_axi_ctrl;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [3:0]  wid_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [3:0]  bid_i = '0;
  logic [1:0]  bresp_i = '0;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [3:0]  rid_i = '0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rlast_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        rready_o;

  int n_tests = 0;
  int n_fail  = 0;

  m_axi_ctrl dut (
    .clk(clk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction against a zero-wait slave that answers with id sid
  task automatic zw(input logic wr, input logic [31:0] addr, input logic [3:0] exp_id,
                    input logic [3:0] sid, input logic last, input logic [1:0] exp_resp);
    chk("zw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = addr ^ 32'h5A5A_0000; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    if (wr) begin
      chk("zw_awvalid", {31'd0, awvalid_o}, 32'd1);
      chk("zw_awid", {28'd0, awid_o}, {28'd0, exp_id});
      awready_i = 1'b1; wready_i = 1'b1;
      tick();
      awready_i = 1'b0; wready_i = 1'b0;
      chk("zw_bready", {31'd0, bready_o}, 32'd1);
      bvalid_i = 1'b1; bid_i = sid; bresp_i = 2'b00;
      tick();
      bvalid_i = 1'b0;
    end else begin
      chk("zw_arvalid", {31'd0, arvalid_o}, 32'd1);
      chk("zw_arid", {28'd0, arid_o}, {28'd0, exp_id});
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0;
      chk("zw_rready", {31'd0, rready_o}, 32'd1);
      rvalid_i = 1'b1; rid_i = sid; rdata_i = ~addr; rresp_i = 2'b00; rlast_i = last;
      tick();
      rvalid_i = 1'b0;
    end
    chk("zw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("zw_rsp_resp", {30'd0, rsp_resp}, {30'd0, exp_resp});
    chk("zw_rsp_rdata", rsp_rdata, wr ? 32'd0 : ~addr);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    // ---- reset values
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_valids", {28'd0, awvalid_o, wvalid_o, arvalid_o, 1'b0}, 32'd0);
    chk("rst_readies", {30'd0, bready_o, rready_o}, 32'd0);
    chk("rst_awaddr", awaddr_o, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    areset = 1'b1;
    tick();

    // ---- write 0xDEADBEEF to 0x4, zero-wait slave
    awready_i = 1'b1; wready_i = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    tick();                                   // cycle 1
    cmd_valid = 1'b0;
    chk("t1_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    chk("t1_awvalid", {31'd0, awvalid_o}, 32'd1);
    chk("t1_wvalid", {31'd0, wvalid_o}, 32'd1);
    chk("t1_awaddr", awaddr_o, 32'h4);
    chk("t1_wdata", wdata_o, 32'hDEADBEEF);
    chk("t1_wstrb", {28'd0, wstrb_o}, 32'hF);
    chk("t1_wlast", {31'd0, wlast_o}, 32'd1);
    chk("t1_awid", {28'd0, awid_o}, 32'd0);
    chk("t1_wid", {28'd0, wid_o}, 32'd0);
    tick();                                   // cycle 2
    awready_i = 1'b0; wready_i = 1'b0;
    chk("t1_valids_low", {30'd0, awvalid_o, wvalid_o}, 32'd0);
    chk("t1_bready", {31'd0, bready_o}, 32'd1);
    chk("t1_rsp_valid_c2", {31'd0, rsp_valid}, 32'd0);
    bvalid_i = 1'b1; bid_i = 4'd0; bresp_i = 2'b00;
    tick();                                   // cycle 3
    bvalid_i = 1'b0;
    chk("t1_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("t1_rsp_rdata", rsp_rdata, 32'd0);
    chk("t1_bready_low", {31'd0, bready_o}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("t1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

    // ---- read 0x8, arready held low for 3 cycles, txn_id 1
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_arvalid_hold", {31'd0, arvalid_o}, 32'd1);
      chk("t2_araddr_hold", araddr_o, 32'h8);
      tick();
    end
    chk("t2_arvalid_c4", {31'd0, arvalid_o}, 32'd1);
    chk("t2_arid", {28'd0, arid_o}, 32'd1);
    chk("t2_rready_early", {31'd0, rready_o}, 32'd0);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    chk("t2_arvalid_low", {31'd0, arvalid_o}, 32'd0);
    chk("t2_rready", {31'd0, rready_o}, 32'd1);
    rvalid_i = 1'b1; rid_i = 4'd1; rdata_i = 32'h12345678; rresp_i = 2'b00; rlast_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t2_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- write where W completes two cycles ahead of AW, txn_id 2
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
    cmd_wdata = 32'h0000A5A5; cmd_wstrb = 4'h3;
    tick();                                   // cycle 1
    cmd_valid = 1'b0;
    wready_i = 1'b1;
    tick();                                   // cycle 2
    wready_i = 1'b0;
    chk("t3_wvalid_dropped", {31'd0, wvalid_o}, 32'd0);
    chk("t3_awvalid_held", {31'd0, awvalid_o}, 32'd1);
    chk("t3_bready_wait", {31'd0, bready_o}, 32'd0);
    tick();                                   // cycle 3
    chk("t3_awvalid_held2", {31'd0, awvalid_o}, 32'd1);
    chk("t3_awaddr_stable", awaddr_o, 32'h10);
    chk("t3_bready_wait2", {31'd0, bready_o}, 32'd0);
    awready_i = 1'b1;
    tick();
    awready_i = 1'b0;
    chk("t3_awvalid_low", {31'd0, awvalid_o}, 32'd0);
    chk("t3_bready", {31'd0, bready_o}, 32'd1);
    bvalid_i = 1'b1; bid_i = 4'd2; bresp_i = 2'b00;
    tick();
    bvalid_i = 1'b0;
    chk("t3_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- read returning rlast=0, txn_id 3
    zw(1'b0, 32'h0000_0030, 4'd3, 4'd3, 1'b0, 2'b10);

    // ---- reset while waiting for B, txn_id 4 is discarded
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    tick();
    cmd_valid = 1'b0;
    awready_i = 1'b1; wready_i = 1'b1;
    tick();
    awready_i = 1'b0; wready_i = 1'b0;
    chk("t5_in_wr_resp", {31'd0, bready_o}, 32'd1);
    #2 areset = 1'b0;
    #1;
    chk("t5_rst_valids", {28'd0, awvalid_o, wvalid_o, arvalid_o, rsp_valid}, 32'd0);
    chk("t5_rst_readies", {30'd0, bready_o, rready_o}, 32'd0);
    @(posedge clk);
    #1 areset = 1'b1;
    tick();
    chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    // bid=3 against txn_id 0 must be flagged
    zw(1'b1, 32'h0000_0020, 4'd0, 4'd3, 1'b1, 2'b10);

    // ---- 17 back-to-back transactions from a fresh reset: ids 0..15 then 0
    areset = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      zw((i % 2) == 0, 32'h100 + 32'(4 * i), 4'(i % 16), 4'(i % 16), 1'b1, 2'b00);
    end

    // ---- response held off for 5 cycles with a new command waiting, txn_id 1
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
    tick();
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rid_i = 4'd1; rdata_i = 32'hCAFEF00D; rresp_i = 2'b01; rlast_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t7_rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      chk("t7_rsp_rdata_hold", rsp_rdata, 32'hCAFEF00D);
      chk("t7_rsp_resp_hold", {30'd0, rsp_resp}, 32'd1);
      chk("t7_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("t7_rsp_released", {31'd0, rsp_valid}, 32'd0);
    chk("t7_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    // the next id follows on from the stalled transaction
    zw(1'b0, 32'h0000_0048, 4'd2, 4'd2, 1'b1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_m_axi_ctrl
`default_nettype wire
